// File: rtl/fpmul_share_ctrl.sv
// fpmul_share_ctrl: round-robin sharing of one multi-cycle FP multiplier among N requesters
module fpmul_share_ctrl #(
  parameter int N = 4,
  parameter int IDW = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [N-1:0]     Req,
  input  logic [32*N-1:0]  ReqA,
  input  logic [32*N-1:0]  ReqB,
  output logic [N-1:0]     Gnt,
  output logic             RespValid,
  input  logic             RespReady,
  output logic [IDW-1:0]   RespId,
  output logic [31:0]      RespProduct,
  output logic             RespOvf,
  output logic             RespUnf,
  output logic             RespErr,
  output logic             MulSt,
  output logic [31:0]      MulA,
  output logic [31:0]      MulB,
  input  logic             MulDone,
  input  logic [31:0]      MulProduct,
  input  logic             MulOvf,
  input  logic             MulUnf
);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t state;
  logic [IDW-1:0] ptr, sel;
  logic [7:0] cnt;
  // first requester at or cyclically after ptr; scanned backwards so the nearest one wins
  always_comb begin
    sel = ptr;
    for (int k = N - 1; k >= 0; k--)
      if (Req[(int'(ptr) + k) % N]) sel = IDW'((int'(ptr) + k) % N);
  end
  // single-job sequencer: grant, start pulse, wait for Done or timeout, hold response until accepted
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      Gnt <= '0;
      MulSt <= 1'b0;
      MulA <= '0;
      MulB <= '0;
      RespValid <= 1'b0;
      RespId <= '0;
      RespProduct <= '0;
      RespOvf <= 1'b0;
      RespUnf <= 1'b0;
      RespErr <= 1'b0;
    end else begin
      Gnt <= '0;
      MulSt <= 1'b0;
      case (state)
        IDLE: if (|Req) begin
          Gnt <= {{(N-1){1'b0}}, 1'b1} << sel;
          MulSt <= 1'b1;
          MulA <= ReqA[32*sel +: 32];
          MulB <= ReqB[32*sel +: 32];
          RespId <= sel;
          ptr <= (sel == IDW'(N - 1)) ? '0 : sel + 1'b1;
          state <= START;
        end
        START: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (MulDone || cnt == 8'(TIMEOUT - 1)) begin
            RespValid <= 1'b1;
            RespErr <= !MulDone;
            RespProduct <= MulDone ? MulProduct : '0;
            RespOvf <= MulDone && MulOvf;
            RespUnf <= MulDone && MulUnf;
            state <= RESP;
          end
        end
        RESP: if (RespReady) begin
          RespValid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
